multu_seq: RTL and testbench

- Multi-cycle sequencer for the MULTU instruction. It owns the HI/LO register pair and runs an iterative shift-add unsigned multiply.
- `start` is driven by the decoded hi/lo write-enable in execute. The block stalls the pipeline when a second MULTU or an MFHI/MFLO arrives while a multiply is in flight.
- The HI/LO read mux (MFHI/MFLO writeback source) reads `hi`/`lo` directly.

---
 rtl/multu_seq.sv | 122 ++++++++++++
 tb/tb_multu_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multu_seq.sv
// multu_seq: multi-cycle MULTU sequencer. It owns the HI/LO register pair and
// computes an unsigned WIDTH x WIDTH product with an iterative shift-add loop.
// The latency is fixed at WIDTH cycles in RUN, with no early exit. While an
// operation is in flight, the block stalls the pipeline front end for a new
// MULTU or an MFHI/MFLO.
module multu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mf_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;

    // Accumulator value after this iteration's conditional add.
    logic [PW-1:0]     acc_sum;

    // Conditional add of the shifted multiplicand. The result cannot exceed 2W bits.
    always_comb begin
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state and datapath control for the IDLE/RUN sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave one unassigned and infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // A start seen here is ignored. The held instruction presents it again later.
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    {hi_d, lo_d} = acc_sum;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. A synchronous reset discards any partial result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Outputs. The stall is combinational so that the request cycle itself is held.
    always_comb begin
        busy  = (state_q == ST_RUN);
        stall = busy & (start | mf_req);
        done  = done_q;
        hi    = hi_q;
        lo    = lo_q;
    end

endmodule

// File: tb/tb_multu_seq.sv
// tb_multu_seq: directed, self-checking bench for multu_seq (WIDTH = 32).
module tb_multu_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mf_req;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    multu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .mf_req (mf_req),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present start for one edge (edge 0), then drop it.
    task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        step();
        start = 1'b0;
    endtask

    // Count busy and stall cycles until the done cycle (bounded), then check the result.
    task automatic wait_done(input string tag, input int exp_busy, input int exp_stall,
                             input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int bcnt = 0;
        int scnt = 0;
        while (busy && bcnt < 100) begin
            #1;
            if (stall) scnt++;
            bcnt++;
            step();
        end
        #1;
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
        check({tag, "_stall_cycles"}, 64'(scnt), 64'(exp_stall));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_stall_in_done"}, 64'(stall), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    // One complete operation from IDLE, followed by the done-drops check.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic hold_mf, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        do_start(av, bv);
        mf_req = hold_mf;
        wait_done(tag, W, hold_mf ? W : 0, exp_hi, exp_lo);
        mf_req = 1'b0;
        step();
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_lo_hold"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int dcnt;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        mf_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        // Basic products and boundary operands.
        run_op("m3x5", 32'd3, 32'd5, 1'b0, 32'h0, 32'h0000000F);
        run_op("mmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mmsb", 32'h8000_0000, 32'd2, 1'b0, 32'h1, 32'h0);

        // mf_req held through RUN with b = 0: a stall on every busy cycle, no early exit.
        run_op("mf_b0", 32'h1234_5678, 32'd0, 1'b1, 32'h0, 32'h0);
        run_op("mf_3x5", 32'd3, 32'd5, 1'b1, 32'h0, 32'd15);

        // A second start is held from cycle 5 of a running op and accepted in the done cycle.
        do_start(32'd3, 32'd5);
        repeat (4) step();
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd6;
        wait_done("b2b_first", W - 4, W - 4, 32'h0, 32'd15);
        step();
        start = 1'b0;
        a     = '1;
        b     = '1;
        check("b2b_accept_busy", 64'(busy), 64'd1);
        check("b2b_accept_done", 64'(done), 64'd0);
        wait_done("b2b_second", W, 0, 32'h0, 32'd42);
        step();

        // A reset at cycle 10 of a run discards the partial result and emits no done pulse.
        do_start(32'd3, 32'd5);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        dcnt = 0;
        repeat (40) begin
            if (done) dcnt++;
            step();
        end
        check("mid_rst_no_done", 64'(dcnt), 64'd0);
        run_op("after_rst", 32'd7, 32'd6, 1'b0, 32'h0, 32'd42);

        // start and mf_req together in IDLE: no stall, the old LO is read, and the multiply starts.
        run_op("pre_idle", 32'd3, 32'd5, 1'b0, 32'h0, 32'd15);
        start  = 1'b1;
        mf_req = 1'b1;
        a      = 32'd2;
        b      = 32'd9;
        #1;
        check("idle_both_stall", 64'(stall), 64'd0);
        check("idle_both_lo_old", 64'(lo), 64'd15);
        step();
        start  = 1'b0;
        mf_req = 1'b0;
        check("idle_both_busy", 64'(busy), 64'd1);
        wait_done("idle_both", W, 0, 32'h0, 32'd18);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
